// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared state and grant encodings for the memory arbiter
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

  localparam int WAIT_W = 8;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way alternating grant decision
module rr_arb2
  import cpu_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  gnt_t last,
  output gnt_t gnt
);

  always_comb begin
    gnt = GNT_I;
    if (i_req && d_req) begin
      gnt = (last == GNT_I) ? GNT_D : GNT_I;
    end else if (d_req) begin
      gnt = GNT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates fetch and load/store requests onto one memory port
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  arb_state_t        state_q, state_d;
  gnt_t              last_q;
  gnt_t              gnt;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              take_grant;
  logic              finish;
  logic              timed_out;

  rr_arb2 u_rr_arb2 (
    .i_req (i_req),
    .d_req (d_req),
    .last  (last_q),
    .gnt   (gnt)
  );

  // mem_ready wins over the timeout when both land in the same cycle
  always_comb begin
    state_d    = state_q;
    take_grant = 1'b0;
    finish     = 1'b0;
    timed_out  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          take_grant = 1'b1;
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (mem_ready) begin
          finish  = 1'b1;
          state_d = ST_DONE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          finish    = 1'b1;
          timed_out = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_q     <= GNT_I;
      wait_cnt_q <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      rdata      <= '0;
      err        <= 1'b0;
    end else begin
      state_q <= state_d;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      if (take_grant) begin
        last_q     <= gnt;
        wait_cnt_q <= '0;
        mem_req    <= 1'b1;
        mem_we     <= (gnt == GNT_D) && d_we;
        mem_addr   <= (gnt == GNT_D) ? d_addr : i_addr;
        mem_wdata  <= (gnt == GNT_D) ? d_wdata : '0;
      end
      if (state_q == ST_ACCESS) begin
        if (finish) begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          err     <= timed_out;
          rdata   <= (mem_ready && !mem_we) ? mem_rdata : '0;
          i_ack   <= (last_q == GNT_I);
          d_ack   <= (last_q == GNT_D);
        end else begin
          wait_cnt_q <= wait_cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [7:0]  i_addr;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [7:0]  d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] rdata;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          acc_cnt  = 0;
  int          ready_delay = 0;
  logic        ready_en = 1'b1;
  logic [15:0] rd_val = 16'h0000;

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .rdata     (rdata),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  // memory model: answers after ready_delay stall cycles of a strobe
  always @(posedge clk) begin
    if (!mem_req) acc_cnt <= 0;
    else          acc_cnt <= acc_cnt + 1;
  end
  assign mem_ready = mem_req && ready_en && (acc_cnt >= ready_delay);
  assign mem_rdata = rd_val;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] seq;
  int         n_acks;

  initial begin
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0;
    tick(); tick();
    check("rst_mem_req", mem_req, 0);
    check("rst_acks", {i_ack, d_ack}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_err", err, 0);
    check("rst_mem_we_addr", {mem_we, mem_addr}, 0);
    rst = 1'b0;
    tick();

    // lone fetch, immediate ready
    ready_delay = 0; ready_en = 1'b1; rd_val = 16'h1234;
    i_req = 1'b1; i_addr = 8'h10;
    check("f_c0_mem_req", mem_req, 0);
    tick();
    check("f_c1_mem_req", mem_req, 1);
    check("f_c1_mem_addr", mem_addr, 8'h10);
    check("f_c1_mem_we", mem_we, 0);
    check("f_c1_acks", {i_ack, d_ack}, 0);
    tick();
    check("f_c2_acks", {i_ack, d_ack}, 2'b10);
    check("f_c2_rdata", rdata, 16'h1234);
    check("f_c2_err", err, 0);
    check("f_c2_mem_req", mem_req, 0);
    i_req = 1'b0;
    tick();
    check("f_c3_acks", {i_ack, d_ack}, 0);

    // simultaneous after reset: data first
    rst = 1'b1; tick(); rst = 1'b0;
    rd_val = 16'h00AA;
    i_req = 1'b1; i_addr = 8'h11; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h22;
    tick();
    check("s_c1_mem_addr", mem_addr, 8'h22);
    tick();
    check("s_c2_acks", {i_ack, d_ack}, 2'b01);
    d_req = 1'b0;
    tick();
    check("s_c3_mem_req", mem_req, 0);
    tick();
    check("s_c4_mem_addr", mem_addr, 8'h11);
    check("s_c4_mem_req", mem_req, 1);
    tick();
    check("s_c5_acks", {i_ack, d_ack}, 2'b10);
    i_req = 1'b0;
    tick();

    // both held: alternating D,I,D,I,D,I
    i_req = 1'b1; d_req = 1'b1; i_addr = 8'h31; d_addr = 8'h32;
    seq = '0; n_acks = 0;
    for (int c = 0; c < 100 && n_acks < 6; c++) begin
      tick();
      if (i_ack || d_ack) begin
        seq[n_acks] = d_ack;
        n_acks++;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    check("alt_count", n_acks, 6);
    check("alt_seq", seq, 6'b010101);
    tick();

    // store with three stall cycles
    ready_delay = 3; rd_val = 16'h5555;
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 16'hBEEF;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("st_mem_req", mem_req, 1);
      check("st_mem_we", mem_we, 1);
      check("st_mem_wdata", mem_wdata, 16'hBEEF);
      check("st_no_ack", d_ack, 0);
    end
    tick();
    check("st_d_ack", {i_ack, d_ack}, 2'b01);
    check("st_rdata", rdata, 0);
    check("st_err", err, 0);
    d_req = 1'b0; d_we = 1'b0;
    tick();

    // timeout with no mem_ready at all
    ready_en = 1'b0; rd_val = 16'h7777;
    i_req = 1'b1; i_addr = 8'h30;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check("to_waiting", {mem_req, i_ack}, 2'b10);
    end
    tick();
    check("to_ack", {i_ack, d_ack}, 2'b10);
    check("to_err", err, 1);
    check("to_rdata", rdata, 0);
    i_req = 1'b0;
    tick();
    ready_en = 1'b1; ready_delay = 0; rd_val = 16'h0F0F;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h31;
    tick(); tick();
    check("after_to_ack", {i_ack, d_ack}, 2'b01);
    check("after_to_err", err, 0);
    check("after_to_rdata", rdata, 16'h0F0F);
    d_req = 1'b0;
    tick();

    // reset in second ACCESS cycle
    ready_delay = 5; rd_val = 16'hCAFE;
    i_req = 1'b1; i_addr = 8'h40;
    tick();
    tick();
    check("ra_c2_mem_req", mem_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; ready_delay = 0;
    check("ra_c3_mem_req", mem_req, 0);
    check("ra_c3_acks", {i_ack, d_ack}, 0);
    check("ra_c3_rdata", rdata, 0);
    tick();
    check("ra_c4_mem_req", mem_req, 1);
    check("ra_c4_acks", {i_ack, d_ack}, 0);
    tick();
    check("ra_c5_acks", {i_ack, d_ack}, 2'b10);
    check("ra_c5_rdata", rdata, 16'hCAFE);
    i_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning memory address width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning memory data width in bits.
REQ-003 The block SHALL have parameter TIMEOUT, default 15, meaning the maximum number of cycles to wait for mem_ready (range 1..255).
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 i_req  in  1  instruction-fetch request, held until i_ack.
REQ-007 i_addr  in  ADDR_W  fetch address, stable while i_req=1.
REQ-008 i_ack  out  1  one-cycle fetch completion pulse.
REQ-009 d_req  in  1  load/store request, held until d_ack.
REQ-010 d_we  in  1  1 = store, 0 = load; stable while d_req=1.
REQ-011 d_addr  in  ADDR_W  data address, stable while d_req=1.
REQ-012 d_wdata  in  DATA_W  store data, stable while d_req=1.
REQ-013 d_ack  out  1  one-cycle data completion pulse.
REQ-014 rdata  out  DATA_W  registered read data, valid in the ack cycle.
REQ-015 err  out  1  timeout flag, valid in the ack cycle.
REQ-016 mem_req  out  1  memory access strobe.
REQ-017 mem_we  out  1  memory write enable.
REQ-018 mem_addr  out  ADDR_W  memory address.
REQ-019 mem_wdata  out  DATA_W  memory write data.
REQ-020 mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1.
REQ-021 mem_ready  in  1  memory completion, sampled only while mem_req=1.

Function
REQ-022 The FSM SHALL have the states IDLE, ACCESS and DONE.
REQ-023 In IDLE with any request pending, the block SHALL grant one requester, register its address/we/wdata, and enter ACCESS on the next edge.
REQ-024 If only one requester is pending in IDLE, that requester SHALL be granted.
REQ-025 If both requesters are pending in IDLE, the requester not granted last SHALL be granted (alternating).
REQ-026 The last-grant register SHALL reset to "instruction", so the first simultaneous request goes to data.
REQ-027 In ACCESS, mem_req SHALL be 1 and mem_addr, mem_we and mem_wdata SHALL be held from the registered values.
REQ-028 mem_we SHALL be 0 for fetches.
REQ-029 In ACCESS, mem_ready=1 SHALL capture mem_rdata into rdata (stores capture 0), clear err, and move the FSM to DONE.
REQ-030 In ACCESS, a wait counter SHALL count cycles with mem_ready=0.
REQ-031 When the wait counter reaches TIMEOUT, the block SHALL set err=1, set rdata=0, and move to DONE.
REQ-032 mem_ready SHALL take precedence over timeout when both occur in the same cycle.
REQ-033 In DONE, exactly one of i_ack/d_ack (the granted requester) SHALL be 1 for one cycle.
REQ-034 In DONE, mem_req SHALL be 0, no new grant SHALL be made, and the next state SHALL be IDLE.
REQ-035 Minimum latency SHALL be: request seen at cycle 0, mem_req=1 at cycle 1, ack at cycle 2 (when mem_ready=1 at cycle 1).
REQ-036 The earliest re-grant SHALL be at cycle 3.
REQ-037 A requester dropping its req while granted SHALL NOT abort the access; the ack is still issued.
REQ-038 A new request arriving during ACCESS or DONE SHALL wait for IDLE.
REQ-039 mem_req and both acks SHALL be register outputs (no combinational path from inputs).

Reset
REQ-040 While rst=1 at a rising edge, the FSM SHALL be set to IDLE.
REQ-041 Reset SHALL clear mem_req, mem_we, mem_addr, mem_wdata, i_ack, d_ack, rdata, err and the wait counter.
REQ-042 Reset SHALL set the last-grant register to "instruction".
REQ-043 Reset during ACCESS SHALL abandon the access with no ack issued.

Structure
REQ-044 The FSM state encoding and the grant enum (GNT_I, GNT_D) SHALL reside in shared package cpu_pkg.
REQ-045 The alternating grant decision SHALL be a sub-module rr_arb2 (inputs: two requests, last grant; output: grant).

Verification
REQ-046 Lone fetch, addr 0x10, mem_ready immediate, mem_rdata 0x1234 -> i_ack at cycle 2, rdata=0x1234, err=0, d_ack never asserted.
REQ-047 i_req and d_req asserted together after reset -> data served first, then fetch; mem_addr sequence d_addr then i_addr; acks in order d_ack then i_ack.
REQ-048 Both requesters held continuously for 6 accesses -> grants alternate D,I,D,I,D,I.
REQ-049 Store d_we=1, addr 0x20, wdata 0xBEEF, mem_ready after 3 wait cycles -> mem_we=1 and mem_wdata=0xBEEF held for 4 cycles, d_ack one cycle later, rdata=0.
REQ-050 mem_ready never asserted, TIMEOUT=15 -> ack after 15 wait cycles with err=1 and rdata=0; the next request completes normally with err=0.
REQ-051 rst asserted in the 2nd ACCESS cycle -> next cycle mem_req=0, no ack; a following fetch completes at minimum latency.
